// File: rtl/serial_data_sender_pkg.sv
// Shared definitions for the serial link: preamble, default sizing and the sender state set.
package NetworkPkg;

    localparam logic [7:0] PREAMBLE        = 8'hA5;
    localparam int         PREAMBLE_W      = 8;
    localparam int         DEFAULT_DATA_W  = 32;
    localparam int         DEFAULT_CLK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAR
    } sender_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_data_sender_bit_period_counter.sv
// Divides clk into bit periods of CLK_DIV cycles; flags the last cycle of each period
// and, one cycle earlier, the cycle before it so callers can register lookahead outputs.
module bit_period_counter #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic period_end_o,
    output logic period_near_end_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] NEAR_CNT = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign period_end_o      = enable_i && !clear_i && (cnt_q == LAST_CNT);
    assign period_near_end_o = enable_i && !clear_i && (cnt_q == NEAR_CNT);

endmodule

// File: rtl/serial_data_sender.sv
// Frames a payload as preamble + data + even parity and shifts it out MSB first,
// one bit every CLK_DIV cycles, with every output driven from a register.
module serial_data_sender
    import NetworkPkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_start,
    input  logic [DATA_W-1:0] pkt_data,
    input  logic              game_active,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              send_done,
    output logic              busy
);

    localparam int BIT_CNT_W = $clog2(max_int(PREAMBLE_W, DATA_W));
    localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(PREAMBLE_W - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);

    sender_state_e         state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  serial_out_q, serial_out_d;
    logic                  serial_valid_q, serial_valid_d;
    logic                  send_done_q, send_done_d;
    logic                  busy_q, busy_d;

    logic                  period_end;
    logic                  period_near_end;
    logic                  period_clear;
    logic [7:0]            preamble_bits;
    logic [2:0]            pre_idx;

    bit_period_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_period (
        .clk               (clk),
        .rst               (rst),
        .enable_i          (state_q != ST_IDLE),
        .clear_i           (period_clear),
        .period_end_o      (period_end),
        .period_near_end_o (period_near_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parity_q       <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            send_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            parity_q       <= parity_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            send_done_q    <= send_done_d;
            busy_q         <= busy_d;
        end
    end

    // Outputs are computed for the next cycle: each branch sets what the line shows after this edge.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        parity_d       = parity_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        send_done_d    = 1'b0;
        busy_d         = busy_q;
        period_clear   = 1'b0;
        preamble_bits  = PREAMBLE;
        pre_idx        = 3'd6 - bit_cnt_q[2:0];

        if (state_q == ST_IDLE) begin
            serial_out_d   = 1'b0;
            serial_valid_d = 1'b0;
            busy_d         = 1'b0;
            if (send_start && game_active) begin
                state_d        = ST_PRE;
                bit_cnt_d      = '0;
                shift_d        = pkt_data;
                parity_d       = ^pkt_data;
                serial_out_d   = preamble_bits[7];
                serial_valid_d = 1'b1;
                busy_d         = 1'b1;
                period_clear   = 1'b1;
            end
        end else if (!game_active) begin
            state_d        = ST_IDLE;
            bit_cnt_d      = '0;
            serial_out_d   = 1'b0;
            serial_valid_d = 1'b0;
            busy_d         = 1'b0;
            period_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_PRE: begin
                    if (period_end) begin
                        if (bit_cnt_q == PRE_LAST) begin
                            state_d      = ST_DATA;
                            bit_cnt_d    = '0;
                            serial_out_d = shift_q[DATA_W-1];
                        end else begin
                            bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
                            serial_out_d = preamble_bits[pre_idx];
                        end
                    end
                end
                ST_DATA: begin
                    if (period_end) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d      = ST_PAR;
                            bit_cnt_d    = '0;
                            serial_out_d = parity_q;
                        end else begin
                            bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
                            shift_d      = shift_q << 1;
                            serial_out_d = shift_d[DATA_W-1];
                        end
                    end
                end
                ST_PAR: begin
                    send_done_d = period_near_end;
                    if (period_end) begin
                        state_d        = ST_IDLE;
                        serial_out_d   = 1'b0;
                        serial_valid_d = 1'b0;
                        busy_d         = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign send_done    = send_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_serial_data_sender.sv
// Randomised self-checking bench for serial_data_sender against a cycle-offset frame model.
module tb_serial_data_sender;

    localparam int DW        = 32;
    localparam int CD        = 4;
    localparam int FRAME_CYC = (9 + DW) * CD;

    logic          clk;
    logic          rst;
    logic          send_start;
    logic [DW-1:0] pkt_data;
    logic          game_active;
    logic          serial_out;
    logic          serial_valid;
    logic          send_done;
    logic          busy;

    int n_checks;
    int n_fail;

    serial_data_sender #(
        .DATA_W  (DW),
        .CLK_DIV (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .send_start   (send_start),
        .pkt_data     (pkt_data),
        .game_active  (game_active),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .send_done    (send_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {serial_out, serial_valid, send_done, busy} c cycles after the accepted start pulse.
    function automatic logic [3:0] exp_outs(input logic [DW-1:0] d, input int c);
        logic [7:0] pre_v;
        logic       b;
        int         k;
        pre_v    = 8'hA5;
        b        = 1'b0;
        exp_outs = 4'b0000;
        if (c >= 1 && c <= FRAME_CYC) begin
            k = (c - 1) / CD;
            if (k < 8)           b = pre_v[7 - k];
            else if (k < 8 + DW) b = d[DW - 1 - (k - 8)];
            else                 b = ^d;
            exp_outs = {b, 1'b1, (c == FRAME_CYC), 1'b1};
        end
    endfunction

    function automatic logic [3:0] got_outs();
        return {serial_out, serial_valid, send_done, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; send_start = 1'b0; game_active = 1'b1; pkt_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_outs() !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b expected=%b", i, got_outs(), 4'b0000);
            end
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pkt_data = $urandom;
            @(negedge clk);
            n_checks++;
            if (got_outs() !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b expected=%b", i, got_outs(), 4'b0000);
            end
            tick();
        end
        $display("reset: 3 cycles held, 20 idle cycles observed");
    endtask

    task automatic test_frames();
        logic [DW-1:0] datas [6];
        datas[0] = 32'hDEADBEEF;
        datas[1] = 32'h00000001;
        for (int j = 2; j < 6; j++) datas[j] = $urandom;
        foreach (datas[j]) begin
            for (int c = 0; c <= FRAME_CYC + 2; c++) begin
                send_start = (c == 0);
                pkt_data   = (c == 0) ? datas[j] : DW'($urandom);
                @(negedge clk);
                n_checks++;
                if (got_outs() !== exp_outs(datas[j], c)) begin
                    n_fail++;
                    $display("FAIL frame data=%h c=%0d got=%b expected=%b",
                             datas[j], c, got_outs(), exp_outs(datas[j], c));
                end
                tick();
            end
            $display("frame: data=%h parity=%0b sent", datas[j], ^datas[j]);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_game_active_drop();
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [3:0]    e;
        d1 = 32'hDEADBEEF;
        d2 = $urandom;
        for (int c = 0; c <= FRAME_CYC + 2; c++) begin
            send_start  = (c == 0) || (c == 60);
            pkt_data    = DW'($urandom);
            if (c == 0) pkt_data = d1;
            if (c == 50) game_active = 1'b0;
            e = (c > 50) ? 4'b0000 : exp_outs(d1, c);
            @(negedge clk);
            n_checks++;
            if (got_outs() !== e) begin
                n_fail++;
                $display("FAIL game_drop c=%0d got=%b expected=%b", c, got_outs(), e);
            end
            tick();
        end
        game_active = 1'b1;
        for (int c = 0; c <= FRAME_CYC + 2; c++) begin
            send_start = (c == 0);
            pkt_data   = (c == 0) ? d2 : DW'($urandom);
            @(negedge clk);
            n_checks++;
            if (got_outs() !== exp_outs(d2, c)) begin
                n_fail++;
                $display("FAIL game_resume data=%h c=%0d got=%b expected=%b",
                         d2, c, got_outs(), exp_outs(d2, c));
            end
            tick();
        end
        $display("game_active drop: frame %h aborted at cycle 50, frame %h sent after", d1, d2);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        d1 = 32'hDEADBEEF;
        d2 = $urandom;
        for (int c = 0; c <= FRAME_CYC; c++) begin
            send_start = (c == 0) || (c == 80);
            pkt_data   = DW'($urandom);
            if (c == 0)  pkt_data = d1;
            if (c == 80) pkt_data = 32'h12345678;
            @(negedge clk);
            n_checks++;
            if (got_outs() !== exp_outs(d1, c)) begin
                n_fail++;
                $display("FAIL busy_ignore c=%0d got=%b expected=%b", c, got_outs(), exp_outs(d1, c));
            end
            tick();
        end
        for (int c = 0; c <= FRAME_CYC + 2; c++) begin
            send_start = (c == 0);
            pkt_data   = (c == 0) ? d2 : DW'($urandom);
            @(negedge clk);
            n_checks++;
            if (got_outs() !== exp_outs(d2, c)) begin
                n_fail++;
                $display("FAIL back_to_back data=%h c=%0d got=%b expected=%b",
                         d2, c, got_outs(), exp_outs(d2, c));
            end
            tick();
        end
        $display("back-to-back: %h (stray start at 80 ignored) then %h", d1, d2);
    endtask

    task automatic test_rst_abort();
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [3:0]    e;
        d1 = $urandom;
        d2 = $urandom;
        for (int c = 0; c <= 102; c++) begin
            send_start = (c == 0);
            pkt_data   = (c == 0) ? d1 : DW'($urandom);
            if (c == 100) rst = 1'b1;
            e = (c >= 100) ? 4'b0000 : exp_outs(d1, c);
            @(negedge clk);
            n_checks++;
            if (got_outs() !== e) begin
                n_fail++;
                $display("FAIL rst_abort c=%0d got=%b expected=%b", c, got_outs(), e);
            end
            tick();
        end
        for (int c = 0; c <= FRAME_CYC + 2; c++) begin
            if (c == 0) rst = 1'b0;
            send_start = (c == 0);
            pkt_data   = (c == 0) ? d2 : DW'($urandom);
            @(negedge clk);
            n_checks++;
            if (got_outs() !== exp_outs(d2, c)) begin
                n_fail++;
                $display("FAIL after_rst data=%h c=%0d got=%b expected=%b",
                         d2, c, got_outs(), exp_outs(d2, c));
            end
            tick();
        end
        $display("rst abort: frame %h cut at cycle 100, frame %h sent right after release", d1, d2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_frames();
        test_game_active_drop();
        test_back_to_back();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_data_sender.md
SERIAL_DATA_SENDER -- requirements
Module: serial_data_sender

Interface
REQ-001 Parameter DATA_W, default 32, payload bits per frame.
REQ-002 Parameter CLK_DIV, default 4, clk cycles per serial bit period (legal range 2..255).
REQ-003 clk  input  1  GPIO clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 send_start  input  1  1-cycle pulse from the sender control FSM; latches pkt_data and starts a frame.
REQ-006 pkt_data  input  DATA_W  payload; sampled only in the send_start cycle.
REQ-007 game_active  input  1  frame proceeds only while high.
REQ-008 serial_out  output  1  serial data line.
REQ-009 serial_valid  output  1  high for every bit period of a frame.
REQ-010 send_done  output  1  1-cycle pulse on completion of a frame.
REQ-011 busy  output  1  high from the cycle after an accepted send_start until frame end or abort.

Function
REQ-012 Frame layout SHALL be: 8-bit PREAMBLE 8'hA5 MSB first, then pkt_data MSB first, then 1 even-parity bit (XOR of all payload bits), for 41 bits at DATA_W=32.
REQ-013 FSM states SHALL be IDLE, PRE, DATA, PAR.
REQ-014 IDLE -> PRE when send_start && game_active; the payload SHALL be latched in the same edge.
REQ-015 With send_start sampled in cycle t, bit k SHALL drive serial_out in cycles t+1+k*CLK_DIV through t+(k+1)*CLK_DIV.
REQ-016 PRE -> DATA after 8 bit periods, DATA -> PAR after DATA_W bit periods, PAR -> IDLE after 1 bit period.
REQ-017 send_done SHALL be high only in the last cycle of the parity bit period, cycle t+(9+DATA_W)*CLK_DIV; busy SHALL be low in the following cycle.
REQ-018 A send_start in the cycle after send_done SHALL be accepted, giving back-to-back frames with no idle bit.
REQ-019 A send_start while busy SHALL be ignored; the latched payload and timing SHALL be unchanged.
REQ-020 game_active low in any non-IDLE state SHALL force IDLE on the next edge, with no send_done and serial_valid low from that cycle.
REQ-021 send_start with game_active low SHALL be ignored.
REQ-022 In IDLE, serial_out, serial_valid, send_done and busy SHALL be 0.
REQ-023 The bit-period counter SHALL wrap from CLK_DIV-1 to 0; the bit counter SHALL be wide enough for max(8, DATA_W)-1 with no overflow.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 On rst: state=IDLE, all counters=0, shift register=0, and serial_out, serial_valid, send_done, busy=0.
REQ-026 rst mid-frame SHALL abort immediately, with no send_done; a send_start in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-027 PREAMBLE, the default DATA_W, the default CLK_DIV and the sender state enum SHALL live in NetworkPkg.
REQ-028 Bit-period timing SHALL be one sub-module, bit_period_counter (inputs: enable and clear; output: 1-cycle period_end pulse), reusable by the receiver.
REQ-029 Payload SHALL be serialised through a single shift register loaded on accept.

Verification (DATA_W=32, CLK_DIV=4)
REQ-030 rst asserted, then idle 20 cycles -> all outputs 0 throughout.
REQ-031 send_start with pkt_data=32'hDEADBEEF at cycle 0:
- serial_out = 10100101, then DEADBEEF MSB first, then parity 0, each bit held 4 cycles from cycle 1;
- serial_valid high cycles 1..164;
- send_done high only at cycle 164.
REQ-032 pkt_data=32'h00000001 -> parity bit 1 in cycles 161..164; bit 39 = 1 in cycles 157..160.
REQ-033 game_active dropped at cycle 50 (DATA state) -> serial_valid and busy 0 from cycle 51; send_done never asserts; a later send_start gives a full correct frame.
REQ-034 second send_start at cycle 80 with 32'h12345678 during a DEADBEEF frame -> ignored, DEADBEEF frame unchanged; a send_start at cycle 165 -> new PREAMBLE bit at cycle 166.
REQ-035 rst pulsed at cycle 100 mid-frame -> all outputs 0 from cycle 100; no send_done.
